// File: rtl/tlb_responder_pkg.sv
// Shared widths, op codes, cache-attribute codes and CP0 register field layout for the TLB.
package tlb_responder_pkg;

  localparam int unsigned VPN2_W  = 19;
  localparam int unsigned ASID_W  = 8;
  localparam int unsigned PFN_W   = 20;
  localparam int unsigned CBITS_W = 3;

  localparam int unsigned EHI_W = VPN2_W + ASID_W;
  localparam int unsigned ELO_W = PFN_W + CBITS_W + 3;

  localparam int unsigned EHI_ASID_LSB = 0;
  localparam int unsigned EHI_VPN2_LSB = ASID_W;

  localparam int unsigned ELO_G_BIT   = 0;
  localparam int unsigned ELO_V_BIT   = 1;
  localparam int unsigned ELO_D_BIT   = 2;
  localparam int unsigned ELO_C_LSB   = 3;
  localparam int unsigned ELO_PFN_LSB = ELO_C_LSB + CBITS_W;

  typedef enum logic [1:0] {
    OP_PROBE      = 2'd0,
    OP_READ       = 2'd1,
    OP_WRITE_IDX  = 2'd2,
    OP_WRITE_RAND = 2'd3
  } op_code_e;

  typedef enum logic [CBITS_W-1:0] {
    C_UNCACHED = 3'd2,
    C_CACHED   = 3'd3
  } cattr_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } op_state_e;

  // Field order matches entryLo bits [ELO_W-1:ELO_V_BIT], so a slice casts directly.
  typedef struct packed {
    logic [PFN_W-1:0]   pfn;
    logic [CBITS_W-1:0] c;
    logic               d;
    logic               v;
  } tlb_lo_t;

  function automatic logic [ELO_W-1:0] lo_pack(input tlb_lo_t f, input logic g);
    logic [ELO_W-1:0] lo;
    lo                             = '0;
    lo[ELO_PFN_LSB +: PFN_W]       = f.pfn;
    lo[ELO_C_LSB +: CBITS_W]       = f.c;
    lo[ELO_D_BIT]                  = f.d;
    lo[ELO_V_BIT]                  = f.v;
    lo[ELO_G_BIT]                  = g;
    return lo;
  endfunction

endpackage

// File: rtl/tlb_responder_match_array.sv
// Combinational fully-associative compare: per-entry match vector plus lowest-index hit/index.
// Ports: entry tags in (valid, global, vpn2, asid), query vpn2/asid in; match_o, hit_o, index_o out.
module tlb_match_array
  import tlb_responder_pkg::*;
#(
  parameter int unsigned TLB_NUM = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic [TLB_NUM-1:0] ent_valid_i,
  input  logic [TLB_NUM-1:0] ent_g_i,
  input  logic [VPN2_W-1:0]  ent_vpn2_i [TLB_NUM],
  input  logic [ASID_W-1:0]  ent_asid_i [TLB_NUM],
  input  logic [VPN2_W-1:0]  vpn2_i,
  input  logic [ASID_W-1:0]  asid_i,
  output logic [TLB_NUM-1:0] match_o,
  output logic               hit_o,
  output logic [IDX_W-1:0]   index_o
);

  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < TLB_NUM; i++) begin
      match_o[i] = ent_valid_i[i] && (ent_vpn2_i[i] == vpn2_i) &&
                   (ent_g_i[i] || (ent_asid_i[i] == asid_i));
    end
  end

  // Scan from the top so the lowest matching index is the last assignment.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    for (int unsigned i = TLB_NUM; i > 0; i--) begin
      if (match_o[i-1]) begin
        hit_o   = 1'b1;
        index_o = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/tlb_responder.sv
// Joint TLB: registered instruction-fetch lookup, CP0 PROBE/READ/WRITE_IDX/WRITE_RAND ops, Random counter.
// Ports: inst_* lookup request/response, op_* handshake, cp0_* op operands, wired_* Wired register,
//        probe_*/rd_* op results, random_o current Random.
module tlb_responder
  import tlb_responder_pkg::*;
#(
  parameter int unsigned TLB_NUM = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_tlbReq_i,
  input  logic [VPN2_W-1:0]  inst_vpn2_i,
  input  logic               inst_oddPage_i,
  input  logic [ASID_W-1:0]  inst_asid_i,
  output logic               inst_hit_o,
  output logic [IDX_W-1:0]   inst_index_o,
  output logic [PFN_W-1:0]   inst_pfn_o,
  output logic [CBITS_W-1:0] inst_c_o,
  output logic               inst_d_o,
  output logic               inst_v_o,
  input  logic               op_valid_i,
  input  logic [1:0]         op_code_i,
  output logic               op_ready_o,
  output logic               op_done_o,
  input  logic [IDX_W-1:0]   cp0_index_i,
  input  logic [EHI_W-1:0]   cp0_entryHi_i,
  input  logic [ELO_W-1:0]   cp0_entryLo0_i,
  input  logic [ELO_W-1:0]   cp0_entryLo1_i,
  input  logic [IDX_W-1:0]   wired_i,
  input  logic               wired_we_i,
  output logic               probe_miss_o,
  output logic [IDX_W-1:0]   probe_index_o,
  output logic [EHI_W-1:0]   rd_entryHi_o,
  output logic [ELO_W-1:0]   rd_entryLo0_o,
  output logic [ELO_W-1:0]   rd_entryLo1_o,
  output logic [IDX_W-1:0]   random_o
);

  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_NUM - 1);

  logic [TLB_NUM-1:0] ent_valid_q;
  logic [TLB_NUM-1:0] ent_g_q;
  logic [VPN2_W-1:0]  ent_vpn2_q [TLB_NUM];
  logic [ASID_W-1:0]  ent_asid_q [TLB_NUM];
  tlb_lo_t            ent_lo0_q  [TLB_NUM];
  tlb_lo_t            ent_lo1_q  [TLB_NUM];

  op_state_e        state_q, state_d;
  logic             latch_en;
  op_code_e         op_code_q;
  logic [IDX_W-1:0] op_idx_q;
  logic [EHI_W-1:0] op_hi_q;
  logic [ELO_W-1:0] op_lo0_q, op_lo1_q;

  logic [IDX_W-1:0] random_q, random_d;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [TLB_NUM-1:0] lk_match, pr_match;
  logic               lk_hit, pr_hit;
  logic [IDX_W-1:0]   lk_idx, pr_idx;
  tlb_lo_t            lk_sel;
  logic               unused_match;

  logic             lk_hit_q;
  logic [IDX_W-1:0] lk_idx_q;
  tlb_lo_t          lk_lo_q;
  logic             probe_miss_q;
  logic [IDX_W-1:0] probe_index_q;
  logic [EHI_W-1:0] rd_hi_q;
  logic [ELO_W-1:0] rd_lo0_q, rd_lo1_q;

  tlb_match_array #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) u_lookup_match (
    .ent_valid_i (ent_valid_q),
    .ent_g_i     (ent_g_q),
    .ent_vpn2_i  (ent_vpn2_q),
    .ent_asid_i  (ent_asid_q),
    .vpn2_i      (inst_vpn2_i),
    .asid_i      (inst_asid_i),
    .match_o     (lk_match),
    .hit_o       (lk_hit),
    .index_o     (lk_idx)
  );

  tlb_match_array #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) u_probe_match (
    .ent_valid_i (ent_valid_q),
    .ent_g_i     (ent_g_q),
    .ent_vpn2_i  (ent_vpn2_q),
    .ent_asid_i  (ent_asid_q),
    .vpn2_i      (op_hi_q[EHI_VPN2_LSB +: VPN2_W]),
    .asid_i      (op_hi_q[EHI_ASID_LSB +: ASID_W]),
    .match_o     (pr_match),
    .hit_o       (pr_hit),
    .index_o     (pr_idx)
  );

  assign unused_match = ^{lk_match, pr_hit};

  always_comb begin
    state_d    = state_q;
    op_ready_o = 1'b0;
    op_done_o  = 1'b0;
    latch_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          latch_en = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        op_done_o = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      op_code_q <= op_code_e'(op_code_i);
      op_idx_q  <= cp0_index_i;
      op_hi_q   <= cp0_entryHi_i;
      op_lo0_q  <= cp0_entryLo0_i;
      op_lo1_q  <= cp0_entryLo1_i;
    end
  end

  // wired_we has priority over both the wrap and the decrement.
  always_comb begin
    random_d = random_q - 1'b1;
    if (wired_we_i || (wired_i >= RAND_TOP) || (random_q == wired_i)) random_d = RAND_TOP;
  end

  always_ff @(posedge clk) begin
    if (rst) random_q <= RAND_TOP;
    else     random_q <= random_d;
  end

  assign wr_en  = (state_q == ST_EXEC) &&
                  ((op_code_q == OP_WRITE_IDX) || (op_code_q == OP_WRITE_RAND));
  assign wr_idx = (op_code_q == OP_WRITE_RAND) ? random_q : op_idx_q;

  always_ff @(posedge clk) begin
    if (rst)        ent_valid_q         <= '0;
    else if (wr_en) ent_valid_q[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      ent_vpn2_q[wr_idx] <= op_hi_q[EHI_VPN2_LSB +: VPN2_W];
      ent_asid_q[wr_idx] <= op_hi_q[EHI_ASID_LSB +: ASID_W];
      ent_g_q[wr_idx]    <= op_lo0_q[ELO_G_BIT] & op_lo1_q[ELO_G_BIT];
      ent_lo0_q[wr_idx]  <= tlb_lo_t'(op_lo0_q[ELO_W-1:ELO_V_BIT]);
      ent_lo1_q[wr_idx]  <= tlb_lo_t'(op_lo1_q[ELO_W-1:ELO_V_BIT]);
    end
  end

  always_comb begin
    lk_sel = '0;
    if (lk_hit) lk_sel = inst_oddPage_i ? ent_lo1_q[lk_idx] : ent_lo0_q[lk_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_hit_q <= 1'b0;
      lk_idx_q <= '0;
      lk_lo_q  <= '0;
    end else if (inst_tlbReq_i) begin
      lk_hit_q <= lk_hit;
      lk_idx_q <= lk_idx;
      lk_lo_q  <= lk_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      probe_miss_q  <= 1'b0;
      probe_index_q <= '0;
      rd_hi_q       <= '0;
      rd_lo0_q      <= '0;
      rd_lo1_q      <= '0;
    end else if (state_q == ST_EXEC) begin
      case (op_code_q)
        OP_PROBE: begin
          probe_miss_q  <= ~|pr_match;
          probe_index_q <= pr_idx;
        end
        OP_READ: begin
          if (ent_valid_q[op_idx_q]) begin
            rd_hi_q  <= {ent_vpn2_q[op_idx_q], ent_asid_q[op_idx_q]};
            rd_lo0_q <= lo_pack(ent_lo0_q[op_idx_q], ent_g_q[op_idx_q]);
            rd_lo1_q <= lo_pack(ent_lo1_q[op_idx_q], ent_g_q[op_idx_q]);
          end else begin
            rd_hi_q  <= '0;
            rd_lo0_q <= '0;
            rd_lo1_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign inst_hit_o    = lk_hit_q;
  assign inst_index_o  = lk_idx_q;
  assign inst_pfn_o    = lk_lo_q.pfn;
  assign inst_c_o      = lk_lo_q.c;
  assign inst_d_o      = lk_lo_q.d;
  assign inst_v_o      = lk_lo_q.v;
  assign probe_miss_o  = probe_miss_q;
  assign probe_index_o = probe_index_q;
  assign rd_entryHi_o  = rd_hi_q;
  assign rd_entryLo0_o = rd_lo0_q;
  assign rd_entryLo1_o = rd_lo1_q;
  assign random_o      = random_q;

endmodule

// File: tb/tb_tlb_responder.sv
module tb_tlb_responder;

  typedef struct packed {
    logic        hit;
    logic [3:0]  idx;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } lk_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_tlbReq_i = 1'b0;
  logic [18:0] inst_vpn2_i = '0;
  logic        inst_oddPage_i = 1'b0;
  logic [7:0]  inst_asid_i = '0;
  logic        inst_hit_o;
  logic [3:0]  inst_index_o;
  logic [19:0] inst_pfn_o;
  logic [2:0]  inst_c_o;
  logic        inst_d_o, inst_v_o;
  logic        op_valid_i = 1'b0;
  logic [1:0]  op_code_i = '0;
  logic        op_ready_o, op_done_o;
  logic [3:0]  cp0_index_i = '0;
  logic [26:0] cp0_entryHi_i = '0;
  logic [25:0] cp0_entryLo0_i = '0;
  logic [25:0] cp0_entryLo1_i = '0;
  logic [3:0]  wired_i = '0;
  logic        wired_we_i = 1'b0;
  logic        probe_miss_o;
  logic [3:0]  probe_index_o;
  logic [26:0] rd_entryHi_o;
  logic [25:0] rd_entryLo0_o, rd_entryLo1_o;
  logic [3:0]  random_o;

  lk_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  tlb_responder #(.TLB_NUM(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .inst_tlbReq_i(inst_tlbReq_i), .inst_vpn2_i(inst_vpn2_i), .inst_oddPage_i(inst_oddPage_i),
    .inst_asid_i(inst_asid_i), .inst_hit_o(inst_hit_o), .inst_index_o(inst_index_o),
    .inst_pfn_o(inst_pfn_o), .inst_c_o(inst_c_o), .inst_d_o(inst_d_o), .inst_v_o(inst_v_o),
    .op_valid_i(op_valid_i), .op_code_i(op_code_i), .op_ready_o(op_ready_o), .op_done_o(op_done_o),
    .cp0_index_i(cp0_index_i), .cp0_entryHi_i(cp0_entryHi_i),
    .cp0_entryLo0_i(cp0_entryLo0_i), .cp0_entryLo1_i(cp0_entryLo1_i),
    .wired_i(wired_i), .wired_we_i(wired_we_i),
    .probe_miss_o(probe_miss_o), .probe_index_o(probe_index_o),
    .rd_entryHi_o(rd_entryHi_o), .rd_entryLo0_o(rd_entryLo0_o), .rd_entryLo1_o(rd_entryLo1_o),
    .random_o(random_o)
  );

  function automatic lk_t cur_lk();
    return {inst_hit_o, inst_index_o, inst_pfn_o, inst_c_o, inst_d_o, inst_v_o};
  endfunction

  // Drives one lookup request cycle; returns #1 after the edge that registers the response.
  task automatic drive_lookup(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid,
                              input lk_t exp);
    inst_vpn2_i    = vpn2;
    inst_oddPage_i = odd;
    inst_asid_i    = asid;
    inst_tlbReq_i  = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    inst_tlbReq_i  = 1'b0;
  endtask

  // Issues an op and waits for op_done; lat = cycles after the accepting edge, -1 on timeout.
  task automatic op_issue(input logic [1:0] code, input logic [3:0] idx, input logic [26:0] hi,
                          input logic [25:0] lo0, input logic [25:0] lo1, output int lat);
    int w;
    op_code_i      = code;
    cp0_index_i    = idx;
    cp0_entryHi_i  = hi;
    cp0_entryLo0_i = lo0;
    cp0_entryLo1_i = lo1;
    op_valid_i     = 1'b1;
    w = 0;
    while (!op_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      if (op_done_o) lat = k;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    lk_t e, got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (random_o !== 4'd15) begin errors++; $display("FAIL reset_random got=%0d exp=15", random_o); end
    checks++;
    if ({op_ready_o, op_done_o} !== 2'b10) begin
      errors++; $display("FAIL reset_handshake got=%b exp=10", {op_ready_o, op_done_o});
    end
    checks++;
    if ({probe_miss_o, probe_index_o, rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o} !== '0) begin
      errors++; $display("FAIL reset_results got=%h exp=0",
                         {probe_miss_o, probe_index_o, rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o});
    end
    drive_lookup(19'h00000, 1'b0, 8'h00, '0);
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_lookup got=%h exp=%h", got, e); end
  endtask

  task automatic test_write_lookup();
    lk_t e, got, e_even;
    int lat;
    op_issue(2'd2, 4'd3, {19'h12345, 8'h05}, {20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b0},
             {20'h11111, 3'd2, 1'b0, 1'b1, 1'b0}, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL write_idx_latency got=%0d exp=2", lat); end
    @(posedge clk); #1;
    checks++;
    if ({op_ready_o, op_done_o} !== 2'b10) begin
      errors++; $display("FAIL done_one_cycle got=%b exp=10", {op_ready_o, op_done_o});
    end
    drive_lookup(19'h12345, 1'b1, 8'h05, {1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b1});
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL lookup_odd got=%h exp=%h", got, e); end
    e_even = {1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1};
    drive_lookup(19'h12345, 1'b0, 8'h05, e_even);
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL lookup_even got=%h exp=%h", got, e); end
    inst_vpn2_i = 19'h7FFFF; inst_asid_i = 8'hEE;
    exp_q.push_back(e_even);
    @(posedge clk); #1;
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL lookup_hold got=%h exp=%h", got, e); end
    drive_lookup(19'h12345, 1'b1, 8'h06, '0);
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL lookup_asid_miss got=%h exp=%h", got, e); end
  endtask

  task automatic test_global_probe();
    lk_t e, got;
    int lat;
    op_issue(2'd2, 4'd7, {19'h2AAAA, 8'h09}, {20'h00777, 3'd3, 1'b0, 1'b1, 1'b1},
             {20'h00888, 3'd2, 1'b1, 1'b0, 1'b1}, lat);
    op_issue(2'd2, 4'd9, {19'h0BEEF, 8'h11}, {20'h00999, 3'd3, 1'b0, 1'b1, 1'b1},
             {20'h00AAA, 3'd2, 1'b0, 1'b1, 1'b0}, lat);
    drive_lookup(19'h2AAAA, 1'b0, 8'h42, {1'b1, 4'd7, 20'h00777, 3'd3, 1'b0, 1'b1});
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL global_even got=%h exp=%h", got, e); end
    drive_lookup(19'h2AAAA, 1'b1, 8'hFF, {1'b1, 4'd7, 20'h00888, 3'd2, 1'b1, 1'b0});
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL global_odd got=%h exp=%h", got, e); end
    drive_lookup(19'h0BEEF, 1'b0, 8'h12, '0);
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL half_g_miss got=%h exp=%h", got, e); end
    drive_lookup(19'h0BEEF, 1'b0, 8'h11, {1'b1, 4'd9, 20'h00999, 3'd3, 1'b0, 1'b1});
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL half_g_hit got=%h exp=%h", got, e); end
    op_issue(2'd0, 4'd0, {19'h12345, 8'h05}, '0, '0, lat);
    checks++;
    if ({probe_miss_o, probe_index_o} !== {1'b0, 4'd3}) begin
      errors++; $display("FAIL probe_hit got=%b/%0d exp=0/3", probe_miss_o, probe_index_o);
    end
    op_issue(2'd0, 4'd0, {19'h2AAAA, 8'h33}, '0, '0, lat);
    checks++;
    if ({probe_miss_o, probe_index_o} !== {1'b0, 4'd7}) begin
      errors++; $display("FAIL probe_global got=%b/%0d exp=0/7", probe_miss_o, probe_index_o);
    end
    op_issue(2'd0, 4'd0, {19'h7FFFF, 8'h00}, '0, '0, lat);
    checks++;
    if ({probe_miss_o, probe_index_o} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL probe_miss got=%b/%0d exp=1/0", probe_miss_o, probe_index_o);
    end
  endtask

  task automatic test_read();
    logic [78:0] exp_rd;
    int lat;
    op_issue(2'd1, 4'd3, '0, '0, '0, lat);
    exp_rd = {19'h12345, 8'h05, 20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b0, 20'h11111, 3'd2, 1'b0, 1'b1, 1'b0};
    checks++;
    if ({rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o} !== exp_rd) begin
      errors++; $display("FAIL read_3 got=%h exp=%h", {rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o}, exp_rd);
    end
    op_issue(2'd1, 4'd9, '0, '0, '0, lat);
    exp_rd = {19'h0BEEF, 8'h11, 20'h00999, 3'd3, 1'b0, 1'b1, 1'b0, 20'h00AAA, 3'd2, 1'b0, 1'b1, 1'b0};
    checks++;
    if ({rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o} !== exp_rd) begin
      errors++; $display("FAIL read_9 got=%h exp=%h", {rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o}, exp_rd);
    end
    op_issue(2'd1, 4'd7, '0, '0, '0, lat);
    exp_rd = {19'h2AAAA, 8'h09, 20'h00777, 3'd3, 1'b0, 1'b1, 1'b1, 20'h00888, 3'd2, 1'b1, 1'b0, 1'b1};
    checks++;
    if ({rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o} !== exp_rd) begin
      errors++; $display("FAIL read_7 got=%h exp=%h", {rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o}, exp_rd);
    end
    op_issue(2'd1, 4'd0, '0, '0, '0, lat);
    checks++;
    if ({rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o} !== '0) begin
      errors++; $display("FAIL read_invalid got=%h exp=0", {rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o});
    end
  endtask

  task automatic test_random();
    lk_t e, got;
    logic [78:0] exp_rd;
    int lat;
    int bad;
    wired_i = 4'd4; wired_we_i = 1'b1;
    @(posedge clk); #1;
    wired_we_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (random_o !== 4'(15 - (k % 12))) begin
        errors++; $display("FAIL random_seq k=%0d got=%0d exp=%0d", k, random_o, 15 - (k % 12));
      end
      @(posedge clk); #1;
    end
    wired_we_i = 1'b1;
    @(posedge clk); #1;
    wired_we_i = 1'b0;
    checks++;
    if (random_o !== 4'd15) begin errors++; $display("FAIL random_wired_we got=%0d exp=15", random_o); end
    @(posedge clk); #1;
    checks++;
    if (random_o !== 4'd14) begin errors++; $display("FAIL random_after_we got=%0d exp=14", random_o); end
    wired_i = 4'd15;
    @(posedge clk); #1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (random_o !== 4'd15) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_pinned got=%0d off-top samples exp=0", bad); end
    wired_i = 4'd4; wired_we_i = 1'b1;
    @(posedge clk); #1;
    wired_we_i = 1'b0;
    op_issue(2'd3, 4'd2, {19'h55555, 8'h22}, {20'h12121, 3'd3, 1'b0, 1'b1, 1'b0},
             {20'h34343, 3'd1, 1'b1, 1'b1, 1'b0}, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL write_rand_latency got=%0d exp=2", lat); end
    op_issue(2'd1, 4'd14, '0, '0, '0, lat);
    exp_rd = {19'h55555, 8'h22, 20'h12121, 3'd3, 1'b0, 1'b1, 1'b0, 20'h34343, 3'd1, 1'b1, 1'b1, 1'b0};
    checks++;
    if ({rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o} !== exp_rd) begin
      errors++; $display("FAIL write_rand_read got=%h exp=%h", {rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o}, exp_rd);
    end
    op_issue(2'd1, 4'd2, '0, '0, '0, lat);
    checks++;
    if ({rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o} !== '0) begin
      errors++; $display("FAIL write_rand_not_index got=%h exp=0", {rd_entryHi_o, rd_entryLo0_o, rd_entryLo1_o});
    end
    drive_lookup(19'h55555, 1'b1, 8'h22, {1'b1, 4'd14, 20'h34343, 3'd1, 1'b1, 1'b1});
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL write_rand_lookup got=%h exp=%h", got, e); end
  endtask

  task automatic test_same_cycle();
    lk_t e, got;
    int w;
    @(posedge clk); #1;
    op_code_i = 2'd2; cp0_index_i = 4'd5; cp0_entryHi_i = {19'h0CAFE, 8'h01};
    cp0_entryLo0_i = {20'h00ABC, 3'd3, 1'b1, 1'b1, 1'b0};
    cp0_entryLo1_i = {20'h00DEF, 3'd2, 1'b0, 1'b1, 1'b0};
    op_valid_i = 1'b1;
    w = 0;
    while (!op_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    checks++;
    if (op_done_o !== 1'b0) begin errors++; $display("FAIL exec_no_done got=%b exp=0", op_done_o); end
    drive_lookup(19'h0CAFE, 1'b0, 8'h01, '0);
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL same_cycle_miss got=%h exp=%h", got, e); end
    checks++;
    if (op_done_o !== 1'b1) begin errors++; $display("FAIL same_cycle_done got=%b exp=1", op_done_o); end
    drive_lookup(19'h0CAFE, 1'b0, 8'h01, {1'b1, 4'd5, 20'h00ABC, 3'd3, 1'b1, 1'b1});
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL next_cycle_hit got=%h exp=%h", got, e); end
  endtask

  task automatic test_hold_valid();
    lk_t e, got;
    int w, dones;
    @(posedge clk); #1;
    op_code_i = 2'd1; cp0_index_i = 4'd3; op_valid_i = 1'b1;
    w = 0;
    while (!op_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    checks++;
    if (op_ready_o !== 1'b0) begin errors++; $display("FAIL exec_not_ready got=%b exp=0", op_ready_o); end
    op_code_i = 2'd2; cp0_index_i = 4'd7; cp0_entryHi_i = {19'h13579, 8'h01};
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    checks++;
    if (rd_entryHi_o !== {19'h12345, 8'h05}) begin
      errors++; $display("FAIL held_valid_read got=%h exp=%h", rd_entryHi_o, {19'h12345, 8'h05});
    end
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (op_done_o) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL held_valid_done_count got=%0d exp=1", dones); end
    drive_lookup(19'h2AAAA, 1'b0, 8'h00, {1'b1, 4'd7, 20'h00777, 3'd3, 1'b0, 1'b1});
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL held_valid_no_write got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset_mid_op();
    lk_t e, got;
    int w, dones;
    @(posedge clk); #1;
    op_code_i = 2'd2; cp0_index_i = 4'd2; cp0_entryHi_i = {19'h01234, 8'h07};
    cp0_entryLo0_i = {20'h0F0F0, 3'd3, 1'b1, 1'b1, 1'b0};
    cp0_entryLo1_i = {20'h0E0E0, 3'd3, 1'b1, 1'b1, 1'b0};
    op_valid_i = 1'b1;
    w = 0;
    while (!op_ready_o && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({op_ready_o, random_o} !== {1'b1, 4'd15}) begin
      errors++; $display("FAIL mid_op_reset_state got=%b/%0d exp=1/15", op_ready_o, random_o);
    end
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      if (op_done_o) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL mid_op_done_count got=%0d exp=0", dones); end
    drive_lookup(19'h01234, 1'b0, 8'h07, '0);
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL mid_op_dropped got=%h exp=%h", got, e); end
    drive_lookup(19'h12345, 1'b1, 8'h05, '0);
    got = cur_lk(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL mid_op_invalidated got=%h exp=%h", got, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_lookup();
    test_global_probe();
    test_read();
    test_random();
    test_same_cycle();
    test_hold_valid();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
